// File: rtl/uart_rx_1.sv
// uart_rx_1 - 8-bit UART receiver with even parity.
//
// Frame: idle high, start bit (0), 8 data bits MSB first, even parity
// bit (XOR of the data bits), stop bit (1). The line is sampled mid-bit
// using a baud counter that runs at CLKS_PER_BIT clocks per bit.
//
// Ports:
//   clk_1        in   clock, all logic on the rising edge
//   rst_1        in   synchronous, active-high reset
//   rx_1         in   serial line, idle high
//   dout_1       out  [7:0] last received byte
//   valid_1      out  one-cycle pulse when dout_1 and the error flags update
//   parity_err_1 out  parity mismatch on the last frame
//   frame_err_1  out  stop bit sampled low on the last frame
//   busy_1       out  high whenever the receiver is not idle
//
// Optional feature macro: UART_RX_SYNC_EN
//   defined   - rx_1 passes through a two-flop synchronizer (adds 2 cycles
//               of latency)
//   undefined - rx_1 feeds the FSM directly (same clock domain as the
//               transmitter)
//
// state  | meaning
// IDLE   | waiting for the line to go low
// START  | counting to mid start bit, confirming it is still low
// DATA   | sampling the 8 data bits
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, publishing the byte
// BREAK  | stop bit was low; waiting for the line to return high

module uart_rx_1 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_1,
    input  logic       rst_1,
    input  logic       rx_1,
    output logic [7:0] dout_1,
    output logic       valid_1,
    output logic       parity_err_1,
    output logic       frame_err_1,
    output logic       busy_1
);

    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shift_reg, shift_nx;
    logic          p_err, p_err_nx;
    logic [7:0]    dout_nx;
    logic          valid_nx, perr_nx, ferr_nx;
    logic          rx_s;

`ifdef UART_RX_SYNC_EN
    logic sync_a, sync_b;

    always_ff @(posedge clk_1) begin
        if (rst_1) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= rx_1;
            sync_b <= sync_a;
        end
    end

    assign rx_s = sync_b;
`else
    assign rx_s = rx_1;
`endif

    assign busy_1 = (state != S_IDLE);

    always_ff @(posedge clk_1) begin
        if (rst_1) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            p_err        <= 1'b0;
            dout_1       <= '0;
            valid_1      <= 1'b0;
            parity_err_1 <= 1'b0;
            frame_err_1  <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            bit_cnt      <= bit_cnt_nx;
            shift_reg    <= shift_nx;
            p_err        <= p_err_nx;
            dout_1       <= dout_nx;
            valid_1      <= valid_nx;
            parity_err_1 <= perr_nx;
            frame_err_1  <= ferr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift_reg;
        p_err_nx   = p_err;
        dout_nx    = dout_1;
        valid_nx   = 1'b0;
        perr_nx    = parity_err_1;
        ferr_nx    = frame_err_1;

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    // With HALF==0 the start edge itself is the mid-bit point.
                    if (HALF == 0) begin
                        state_nx = S_DATA;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = S_START;
                        cnt_nx   = CW'(1);
                    end
                end
            end
            S_START: begin
                if (cnt == HALF_C) begin
                    cnt_nx   = '0;
                    state_nx = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt == LAST_C) begin
                    shift_nx   = {shift_reg[6:0], rx_s};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    cnt_nx     = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nx = S_PARITY;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_PARITY: begin
                if (cnt == LAST_C) begin
                    p_err_nx = rx_s ^ (^shift_reg);
                    cnt_nx   = '0;
                    state_nx = S_STOP;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt == LAST_C) begin
                    dout_nx  = shift_reg;
                    valid_nx = 1'b1;
                    perr_nx  = p_err;
                    ferr_nx  = ~rx_s;
                    cnt_nx   = '0;
                    // A low stop bit must not be mistaken for the next start.
                    state_nx = rx_s ? S_IDLE : S_BREAK;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_1.sv
// Testbench for uart_rx_1: one instance at CLKS_PER_BIT=1 (dut_a) and one
// at CLKS_PER_BIT=16 (dut_b). Expected frames are queued when driven and
// compared when valid_1 pulses.

module tb_uart_rx_1;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       rst_a, rx_a, valid_a, perr_a, ferr_a, busy_a;
    logic [7:0] dout_a;
    logic       rst_b, rx_b, valid_b, perr_b, ferr_b, busy_b;
    logic [7:0] dout_b;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int va_count = 0;
    int vb_count = 0;
    int va_prev  = 0;
    int va_last  = 0;

    uart_rx_1 #(.CLKS_PER_BIT(1)) dut_a (
        .clk_1(clk), .rst_1(rst_a), .rx_1(rx_a), .dout_1(dout_a),
        .valid_1(valid_a), .parity_err_1(perr_a), .frame_err_1(ferr_a),
        .busy_1(busy_a)
    );

    uart_rx_1 #(.CLKS_PER_BIT(16)) dut_b (
        .clk_1(clk), .rst_1(rst_b), .rx_1(rx_b), .dout_1(dout_b),
        .valid_1(valid_b), .parity_err_1(perr_b), .frame_err_1(ferr_b),
        .busy_1(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            va_count++;
            va_prev = va_last;
            va_last = cyc;
            if (q_a.size() == 0) begin
                check_val("a_unexpected_valid", 32'(valid_a), 32'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check_val("a_dout", 32'(dout_a), 32'(e.d));
                check_val("a_parity_err", 32'(perr_a), 32'(e.pe));
                check_val("a_frame_err", 32'(ferr_a), 32'(e.fe));
            end
        end
        if (valid_b === 1'b1) begin
            vb_count++;
            if (q_b.size() == 0) begin
                check_val("b_unexpected_valid", 32'(valid_b), 32'd0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check_val("b_dout", 32'(dout_b), 32'(e.d));
                check_val("b_parity_err", 32'(perr_b), 32'(e.pe));
                check_val("b_frame_err", 32'(ferr_b), 32'(e.fe));
            end
        end
    end

    // one bit on dut_a's line (one clock)
    task automatic bit_a(input logic v);
        rx_a = v;
        @(posedge clk);
        #1;
    endtask

    // one bit on dut_b's line (16 clocks)
    task automatic bit_b(input logic v);
        rx_b = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    // transmitter pattern: idle cycle, start, 8 data MSB first, parity, stop
    task automatic send_a(input logic [7:0] d, input logic par);
        exp_t e;
        bit_a(1'b1);
        bit_a(1'b0);
        for (int i = 7; i >= 0; i--) bit_a(d[i]);
        bit_a(par);
        e.d  = d;
        e.pe = par ^ (^d);
        e.fe = 1'b0;
        q_a.push_back(e);
        bit_a(1'b1);
    endtask

    initial begin
        exp_t e;
        logic [7:0] ab;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("a_rst_dout", 32'(dout_a), 32'd0);
        check_val("a_rst_valid", 32'(valid_a), 32'd0);
        check_val("a_rst_perr", 32'(perr_a), 32'd0);
        check_val("a_rst_ferr", 32'(ferr_a), 32'd0);
        check_val("a_rst_busy", 32'(busy_a), 32'd0);
        check_val("b_rst_dout", 32'(dout_b), 32'd0);
        check_val("b_rst_valid", 32'(valid_b), 32'd0);
        check_val("b_rst_perr", 32'(perr_b), 32'd0);
        check_val("b_rst_ferr", 32'(ferr_b), 32'd0);
        check_val("b_rst_busy", 32'(busy_b), 32'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        bit_a(1'b1);

        // clean frame, then a parity error
        send_a(8'hA5, 1'b0);
        send_a(8'h01, 1'b0);
        bit_a(1'b1);
        @(negedge clk);
        check_val("a_idle_busy", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1;

        // reset during the 4th data bit abandons the frame
        ab = 8'h96;
        bit_a(1'b1);
        bit_a(1'b0);
        bit_a(ab[7]);
        bit_a(ab[6]);
        bit_a(ab[5]);
        rst_a = 1'b1;
        bit_a(ab[4]);
        rst_a = 1'b0;
        @(negedge clk);
        check_val("a_abort_dout", 32'(dout_a), 32'd0);
        check_val("a_abort_busy", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1;
        repeat (12) bit_a(1'b1);
        send_a(8'h5A, 1'b0);
        repeat (3) bit_a(1'b1);
        check_val("a_after_abort_dout", 32'(dout_a), 32'h5A);

        // two frames with one extra idle cycle between transmitter patterns
        send_a(8'h12, 1'b0);
        bit_a(1'b1);
        send_a(8'h34, 1'b1);
        repeat (3) bit_a(1'b1);
        check_val("a_pulse_gap", 32'(va_last - va_prev), 32'd13);
        check_val("a_last_dout", 32'(dout_a), 32'h34);

        // dut_b: 0x3C with stop held low for 40 cycles
        bit_b(1'b1);
        bit_b(1'b0);
        for (int i = 7; i >= 0; i--) bit_b(logic'((8'h3C >> i) & 8'h01));
        bit_b(1'b0);
        e.d  = 8'h3C;
        e.pe = 1'b0;
        e.fe = 1'b1;
        q_b.push_back(e);
        rx_b = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_val("b_break_busy", 32'(busy_b), 32'd1);
        check_val("b_break_ferr", 32'(ferr_b), 32'd1);
        @(posedge clk);
        #1;
        rx_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("b_break_release_busy", 32'(busy_b), 32'd0);
        @(posedge clk);
        #1;

        // 3-cycle low glitch on the idle line
        rx_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_b = 1'b1;
        @(negedge clk);
        check_val("b_glitch_busy_hi", 32'(busy_b), 32'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("b_glitch_busy_lo", 32'(busy_b), 32'd0);
        check_val("b_glitch_dout", 32'(dout_b), 32'h3C);
        check_val("b_glitch_ferr", 32'(ferr_b), 32'd1);
        check_val("b_glitch_perr", 32'(perr_b), 32'd0);
        repeat (40) @(posedge clk);

        @(negedge clk);
        check_val("a_valid_count", 32'(va_count), 32'd5);
        check_val("b_valid_count", 32'(vb_count), 32'd1);
        check_val("a_queue_left", 32'(q_a.size()), 32'd0);
        check_val("b_queue_left", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
